// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order reads at the current pc, buffers returned words
// with their address, and presents them to decode over a valid/ready handshake.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_advance,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
);
  // Handshakes: a transfer happens on a cycle where both sides of the pair are
  // high (imem_req&&imem_gnt, inst_valid&&inst_ready); the offering side holds
  // its request and payload stable until that cycle, except imem_req on flush.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         fifo_count;
  logic [PW-1:0]         tag_wptr;
  logic [PW-1:0]         tag_rptr;
  logic [PW-1:0]         fifo_wptr;
  logic [PW-1:0]         fifo_rptr;
  logic [ADDR_WIDTH-1:0] tag_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic                  grant;
  logic                  rsp_live;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [SW-1:0]         occupied;

  assign fifo_pop  = inst_valid && inst_ready;
  assign rsp_live  = imem_rvalid && (drop == '0);
  assign fifo_push = rsp_live && !flush;

  // Stale responses still owed by memory hold a slot; a slot freed by this
  // cycle's pop is reusable at once so a ready decoder sees one word per cycle.
  assign occupied = SW'(outstanding) + SW'(drop) + SW'(fifo_count) - SW'(fifo_pop);

  assign imem_req   = !reset && !flush && (occupied < SW'(FIFO_DEPTH));
  assign imem_addr  = pc;
  assign grant      = imem_req && imem_gnt;
  assign pc_advance = grant;

  assign inst_valid = (fifo_count != '0);
  assign inst_data  = data_mem[fifo_rptr];
  assign inst_pc    = pc_mem[fifo_rptr];

  // A flush turns everything in flight into responses to be discarded,
  // including one arriving in the flush cycle itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      drop        <= '0;
    end else if (flush) begin
      outstanding <= '0;
      drop        <= drop + outstanding - CW'(imem_rvalid);
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(rsp_live);
      if (imem_rvalid && (drop != '0)) drop <= drop - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
    end else if (flush) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
    end else begin
      if (grant)    tag_wptr <= tag_wptr + PW'(1);
      if (rsp_live) tag_rptr <= tag_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wptr] <= pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wptr  <= '0;
      fifo_rptr  <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      fifo_wptr  <= '0;
      fifo_rptr  <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        data_mem[fifo_wptr] <= imem_rdata;
        pc_mem[fifo_wptr]   <= tag_mem[tag_rptr];
        fifo_wptr           <= fifo_wptr + PW'(1);
      end
      if (fifo_pop) fifo_rptr <= fifo_rptr + PW'(1);
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a program_counter model and an
// in-order instruction memory model of programmable grant/latency.
module tb_instruction_fetch;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          pc_advance;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  logic [AW-1:0] jb_target;
  int            lat;
  int            cyc;
  bit            pop_pend = 1'b0;
  logic [AW-1:0] addr_q[$];
  int            due_q[$];
  int            n_checks = 0;
  int            n_fails  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // program_counter: jumps on flush, otherwise steps only on pc_advance
  always @(posedge clk or posedge reset) begin
    if (reset)           pc <= '0;
    else if (flush)      pc <= jb_target;
    else if (pc_advance) pc <= pc + 32'd4;
  end

  // Memory: grants and consumed responses observed mid-cycle
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (imem_rvalid) pop_pend = 1'b1;
      if (imem_req && imem_gnt) begin
        addr_q.push_back(imem_addr);
        due_q.push_back(cyc + lat);
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q.delete();
      due_q.delete();
      pop_pend    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      cyc         = 0;
    end else begin
      #1;
      cyc++;
      if (pop_pend && addr_q.size() > 0) begin
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end
      pop_pend = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(addr_q[0]);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // A full buffer must never see a push without a matching pop
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_checks++;
      assert (!(dut.fifo_push && !dut.fifo_pop && dut.fifo_count == DEPTH))
      else begin
        n_fails++;
        $error("FAIL fifo_overflow: observed push into full buffer (count %0d), expected none",
               dut.fifo_count);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; inst_ready = 1'b1; imem_gnt = 1'b1;
    lat = 1; jb_target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_req",   32'(imem_req),   32'h0);
    chk("rst_adv",   32'(pc_advance), 32'h0);
    chk("rst_data",  inst_data,       32'h0);
    chk("rst_pc",    inst_pc,         32'h0);

    // Streaming with 1-cycle memory
    reset = 1'b0;
    #1;
    chk("c0_req",   32'(imem_req),   32'h1);
    chk("c0_addr",  imem_addr,       32'h0);
    chk("c0_adv",   32'(pc_advance), 32'h1);
    chk("c0_valid", 32'(inst_valid), 32'h0);
    step();
    chk("c1_valid", 32'(inst_valid), 32'h0);
    chk("c1_addr",  imem_addr,       32'h4);
    chk("c1_adv",   32'(pc_advance), 32'h1);
    step();
    chk("c2_valid", 32'(inst_valid), 32'h1);
    chk("c2_pc",    inst_pc,         32'h0);
    chk("c2_data",  inst_data,       32'hC0DE_0000);
    chk("c2_adv",   32'(pc_advance), 32'h1);
    chk("c2_addr",  imem_addr,       32'h8);
    step();
    chk("c3_pc",    inst_pc,         32'h4);
    chk("c3_data",  inst_data,       32'hC0DE_0004);
    chk("c3_adv",   32'(pc_advance), 32'h1);

    // Decode stalls for 5 cycles
    step();
    inst_ready = 1'b0;
    #1;
    chk("c4_req",   32'(imem_req),   32'h0);
    chk("c4_adv",   32'(pc_advance), 32'h0);
    chk("c4_pc",    inst_pc,         32'h8);
    step();
    chk("c5_pc",    inst_pc,         32'h8);
    step();
    chk("c6_req",   32'(imem_req),   32'h0);
    chk("c6_adv",   32'(pc_advance), 32'h0);
    chk("c6_pc",    inst_pc,         32'h8);
    chk("c6_data",  inst_data,       32'hC0DE_0008);
    chk("c6_addr",  imem_addr,       32'h10);
    step();
    step();
    chk("c8_valid", 32'(inst_valid), 32'h1);
    chk("c8_pc",    inst_pc,         32'h8);

    // Resume decode; memory withholds grant for 3 cycles on 0x10
    step();
    inst_ready = 1'b1;
    imem_gnt   = 1'b0;
    #1;
    chk("c9_req",   32'(imem_req),   32'h1);
    chk("c9_addr",  imem_addr,       32'h10);
    chk("c9_adv",   32'(pc_advance), 32'h0);
    chk("c9_pc",    inst_pc,         32'h8);
    step();
    chk("c10_pc",   inst_pc,         32'hC);
    chk("c10_data", inst_data,       32'hC0DE_000C);
    chk("c10_req",  32'(imem_req),   32'h1);
    chk("c10_addr", imem_addr,       32'h10);
    chk("c10_adv",  32'(pc_advance), 32'h0);
    step();
    chk("c11_valid", 32'(inst_valid), 32'h0);
    chk("c11_req",   32'(imem_req),   32'h1);
    chk("c11_addr",  imem_addr,       32'h10);
    chk("c11_adv",   32'(pc_advance), 32'h0);
    step();
    imem_gnt = 1'b1;
    #1;
    chk("c12_adv",  32'(pc_advance), 32'h1);
    chk("c12_addr", imem_addr,       32'h10);
    step();
    chk("c13_valid", 32'(inst_valid), 32'h0);
    chk("c13_addr",  imem_addr,       32'h14);
    step();
    lat = 3;
    chk("c14_pc",   inst_pc,   32'h10);
    chk("c14_data", inst_data, 32'hC0DE_0010);
    step();
    chk("c15_pc",   inst_pc,   32'h14);

    // Two slow fetches outstanding, then a jump to 100
    step();
    chk("c16_valid", 32'(inst_valid), 32'h0);
    chk("c16_req",   32'(imem_req),   32'h0);
    flush = 1'b1;
    jb_target = 32'd100;
    #1;
    chk("c16_fl_adv", 32'(pc_advance), 32'h0);
    step();
    flush = 1'b0;
    lat = 1;
    #1;
    chk("c17_valid", 32'(inst_valid), 32'h0);
    chk("c17_req",   32'(imem_req),   32'h0);
    chk("c17_addr",  imem_addr,       32'h64);
    step();
    chk("c18_valid", 32'(inst_valid), 32'h0);
    chk("c18_req",   32'(imem_req),   32'h1);
    chk("c18_addr",  imem_addr,       32'h64);
    chk("c18_adv",   32'(pc_advance), 32'h1);
    step();
    chk("c19_valid", 32'(inst_valid), 32'h0);
    chk("c19_addr",  imem_addr,       32'h68);
    step();
    chk("c20_valid", 32'(inst_valid), 32'h1);
    chk("c20_pc",    inst_pc,         32'h64);
    chk("c20_data",  inst_data,       32'hC0DE_0064);

    // Flush coincident with a response and a decode pop
    step();
    chk("c21_pc", inst_pc, 32'h68);
    flush = 1'b1;
    jb_target = 32'h200;
    #1;
    chk("c21_req", 32'(imem_req),   32'h0);
    chk("c21_adv", 32'(pc_advance), 32'h0);
    step();
    flush = 1'b0;
    #1;
    chk("c22_valid", 32'(inst_valid), 32'h0);
    chk("c22_req",   32'(imem_req),   32'h1);
    chk("c22_addr",  imem_addr,       32'h200);
    chk("c22_adv",   32'(pc_advance), 32'h1);
    step();
    chk("c23_valid", 32'(inst_valid), 32'h0);
    step();
    lat = 3;
    chk("c24_valid", 32'(inst_valid), 32'h1);
    chk("c24_pc",    inst_pc,         32'h200);
    chk("c24_data",  inst_data,       32'hC0DE_0200);
    step();
    chk("c25_pc",    inst_pc,         32'h204);
    chk("c25_data",  inst_data,       32'hC0DE_0204);

    // Asynchronous reset mid-cycle with fetches in flight
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(inst_valid), 32'h0);
    chk("ar_req",   32'(imem_req),   32'h0);
    chk("ar_adv",   32'(pc_advance), 32'h0);
    chk("ar_data",  inst_data,       32'h0);
    chk("ar_pc",    inst_pc,         32'h0);
    repeat (2) @(posedge clk);
    #1;
    lat = 1;
    reset = 1'b0;
    #1;
    chk("r0_req",   32'(imem_req),   32'h1);
    chk("r0_addr",  imem_addr,       32'h0);
    chk("r0_valid", 32'(inst_valid), 32'h0);
    step();
    chk("r1_valid", 32'(inst_valid), 32'h0);
    chk("r1_addr",  imem_addr,       32'h4);
    step();
    chk("r2_valid", 32'(inst_valid), 32'h1);
    chk("r2_pc",    inst_pc,         32'h0);
    chk("r2_data",  inst_data,       32'hC0DE_0000);
    step();
    chk("r3_pc",    inst_pc,         32'h4);
    chk("r3_data",  inst_data,       32'hC0DE_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
